// File: rtl/vga_pixel_sink.sv
// ---------------------------------------------------------------------------
// vga_pixel_sink
//
// Buffers pixel write requests (colour + linear address) in a small FIFO and
// drains them one at a time through a decode engine. The engine splits the
// linear address into (x, y) by restoring division by SCREEN_W, producing
// one quotient bit per cycle. It then pulses plot for one cycle towards a
// VGA adapter. Addresses outside the screen are counted and never plotted.
//
// Ports
//   clk              system clock, rising-edge active
//   resetn           asynchronous active-low reset
//   colour[8:0]      requested colour {R[2:0], G[2:0], B[2:0]}
//   coordinates[14:0] linear address y*SCREEN_W + x
//   VGA_write_enable request strobe, one request per cycle while high
//   fifo_full        buffer holds FIFO_DEPTH entries
//   x[7:0], y[6:0]   decoded column / row
//   vga_colour[8:0]  colour to the adapter
//   plot             single-cycle write strobe
//   idle             buffer empty and engine idle
//   range_err_count  saturating count of out-of-range addresses
//   overflow         sticky: a request arrived while fifo_full was high
// ---------------------------------------------------------------------------
module vga_pixel_sink #(
    parameter int FIFO_DEPTH = 8,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [8:0]  colour,
    input  logic [14:0] coordinates,
    input  logic        VGA_write_enable,
    output logic        fifo_full,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [8:0]  vga_colour,
    output logic        plot,
    output logic        idle,
    output logic [7:0]  range_err_count,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] PIXELS_L = 16'(SCREEN_W * SCREEN_H);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_PLOT = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [23:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [23:0]   head_s;
    logic          push_s;
    logic          pop_s;

    // Engine state
    state_t        state_q;
    logic [2:0]    k_q;
    logic [15:0]   rem_q;
    logic [15:0]   rem_d;
    logic [6:0]    quo_q;
    logic [6:0]    quo_d;
    logic [8:0]    col_q;
    logic [23:0]   div_step_s;

    // Registered outputs
    logic [7:0]    x_q;
    logic [6:0]    y_q;
    logic [8:0]    vga_colour_q;
    logic          plot_q;
    logic [7:0]    err_q;
    logic          overflow_q;

    assign fifo_full       = (count_q == CW'(FIFO_DEPTH));
    assign idle            = (state_q == ST_IDLE) && (count_q == '0);
    assign x               = x_q;
    assign y               = y_q;
    assign vga_colour      = vga_colour_q;
    assign plot            = plot_q;
    assign range_err_count = err_q;
    assign overflow        = overflow_q;

    // The full test uses the pre-edge count, so a same-cycle pop never frees a slot for a push.
    assign push_s = VGA_write_enable && !fifo_full;
    assign pop_s  = (state_q == ST_IDLE) && (count_q != '0);
    assign head_s = mem_q[rd_ptr_q];

    // Entry count next-state: simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // One restoring-division step: compare against SCREEN_W shifted to bit k
    always_comb begin
        div_step_s = 24'(SCREEN_W) << k_q;
        if ({8'd0, rem_q} >= div_step_s) begin
            rem_d = rem_q - div_step_s[15:0];
            quo_d = quo_q | (7'd1 << k_q);
        end else begin
            rem_d = rem_q;
            quo_d = quo_q;
        end
    end

    // FIFO data array; contents are meaningless after reset because the pointers clear
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {colour, coordinates};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (VGA_write_enable && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Decode engine: IDLE pops and range-checks, DIV makes quotient bits 6..0, PLOT strobes once
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            k_q          <= 3'd0;
            rem_q        <= 16'd0;
            quo_q        <= 7'd0;
            col_q        <= 9'd0;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            vga_colour_q <= 9'd0;
            plot_q       <= 1'b0;
            err_q        <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    plot_q <= 1'b0;
                    if (pop_s) begin
                        col_q <= head_s[23:15];
                        if ({1'b0, head_s[14:0]} >= PIXELS_L) begin
                            if (err_q != 8'hFF) begin
                                err_q <= err_q + 8'd1;
                            end
                        end else begin
                            rem_q   <= {1'b0, head_s[14:0]};
                            quo_q   <= 7'd0;
                            k_q     <= 3'd6;
                            state_q <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (k_q == 3'd0) begin
                        // Outputs are loaded together with the strobe so they are valid while plot=1
                        state_q      <= ST_PLOT;
                        plot_q       <= 1'b1;
                        x_q          <= rem_d[7:0];
                        y_q          <= quo_d;
                        vga_colour_q <= col_q;
                    end else begin
                        k_q <= k_q - 3'd1;
                    end
                end
                ST_PLOT: begin
                    plot_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    plot_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
